reservation_station: RTL

// - Parametrised out-of-order issue queue between rename/dispatch and the ALU.
// - Holds up to L decoded ops and snoops NUM_WB result-broadcast channels to mark sources ready.
// - Issues one ready op per cycle over a valid/ready handshake.
// - Selection is lowest-index or oldest-first, set by SEL_OLDEST.
// - Replaces the fixed-depth, wakeup-less, handshake-less execution buffer.

---
 rtl/nand_cpu_pkg.sv | 52 +++++
 rtl/rs_age_matrix.sv | 49 ++++
 rtl/reservation_station.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nand_cpu_pkg.sv
// Shared CPU definitions: register-file widths, ALU opcodes and the
// decoded-op record carried from rename/dispatch to the ALU.
package nand_cpu_pkg;

  localparam int unsigned NUM_D_REG = 64;
  localparam int unsigned NUM_S_REG = 8;
  localparam int unsigned NUM_ROB   = 32;

  localparam int unsigned DREG_W = $clog2(NUM_D_REG);
  localparam int unsigned SREG_W = $clog2(NUM_S_REG);
  localparam int unsigned ROB_W  = $clog2(NUM_ROB);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_LD   = 4'd12,
    ALU_ST   = 4'd13,
    ALU_BR   = 4'd14,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_addr;
    alu_op_e           alu_op;
    logic [5:0]        immdt;
    logic              use_ra;
    logic [DREG_W-1:0] ra_addr;
    logic              ra_ready;
    logic              use_rt;
    logic [DREG_W-1:0] rt_addr;
    logic              rt_ready;
    logic [DREG_W-1:0] rw_addr;
    logic [15:0]       rv_addr;
    logic [SREG_W-1:0] rs_addr;
  } rs_op_t;

  // An op may issue once every source it actually uses has been produced.
  function automatic logic op_srcs_ready(input rs_op_t op);
    return (~op.use_ra | op.ra_ready) & (~op.use_rt | op.rt_ready);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker for the issue queue. age_q[i][j]=1 means entry i
// was allocated before entry j; the oldest ready entry is the ready entry
// that no other ready entry is older than.
module rs_age_matrix #(
  parameter int unsigned L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [L-1:0] alloc_vec,
  input  logic [L-1:0] valid_vec,
  input  logic [L-1:0] ready_vec,
  output logic [L-1:0] oldest_vec
);

  logic [L-1:0][L-1:0] age_q, age_d;
  logic [L-1:0]        blocked;

  // Allocation makes the new entry younger than every live entry. The column
  // is assigned (not just set) so stale bits from dead entries are scrubbed.
  always_comb begin
    age_d = age_q;
    for (int unsigned k = 0; k < L; k++) begin
      if (alloc_vec[k]) begin
        for (int unsigned j = 0; j < L; j++) begin
          age_d[k][j] = 1'b0;
          if (j != k) age_d[j][k] = valid_vec[j];
        end
      end
    end
  end

  // Age state register.
  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  // An entry is blocked if some other ready entry is older than it.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < L; i++) begin
      for (int unsigned j = 0; j < L; j++) begin
        if (j != i && ready_vec[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
    end
    oldest_vec = ready_vec & ~blocked;
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue queue: accepts decoded ops from dispatch, snoops the
// result-broadcast buses to wake sources, and offers one ready op per cycle
// to the ALU over a valid/ready handshake.
module reservation_station
  import nand_cpu_pkg::*;
#(
  parameter int unsigned L          = 8,
  parameter int unsigned NUM_WB     = 2,
  parameter int unsigned SEL_OLDEST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  rs_op_t                        in_op,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB-1:0][DREG_W-1:0] wb_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output rs_op_t                        out_op,
  output logic [$clog2(L+1)-1:0]        count
);

  localparam int unsigned CNT_W = $clog2(L+1);
  localparam int unsigned IDX_W = $clog2(L);

  logic [L-1:0]       valid_q, valid_d;
  rs_op_t [L-1:0]     ent_q, ent_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [L-1:0]       ready_vec;
  logic [L-1:0]       sel_vec;
  logic [L-1:0]       alloc_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_fire;
  logic               issue_fire;
  rs_op_t             disp_op;

  function automatic logic wb_hit(
    input logic [DREG_W-1:0]             addr,
    input logic [NUM_WB-1:0]             v,
    input logic [NUM_WB-1:0][DREG_W-1:0] a
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < NUM_WB; w++) begin
      if (v[w] && a[w] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-entry readiness from registered state only.
  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < L; i++) begin
      ready_vec[i] = valid_q[i] & op_srcs_ready(ent_q[i]);
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = L; i > 0; i--) begin
      if (!valid_q[i-1]) free_idx = IDX_W'(i-1);
    end
  end

  assign in_ready   = (count_q != CNT_W'(L));
  assign disp_fire  = in_valid & in_ready & ~flush;
  assign out_valid  = (|ready_vec) & ~flush;
  assign issue_fire = out_valid & out_ready;
  assign count      = count_q;

  // One-hot allocation vector for the slot being written this cycle.
  always_comb begin
    alloc_vec = '0;
    for (int unsigned i = 0; i < L; i++) begin
      alloc_vec[i] = disp_fire && (free_idx == IDX_W'(i));
    end
  end

  generate
    if (SEL_OLDEST != 0) begin : g_age
      rs_age_matrix #(.L(L)) u_age (
        .clk        (clk),
        .rst        (rst),
        .alloc_vec  (alloc_vec),
        .valid_vec  (valid_q),
        .ready_vec  (ready_vec),
        .oldest_vec (sel_vec)
      );
    end else begin : g_prio
      logic found;
      // Lowest-index ready entry wins.
      always_comb begin
        sel_vec = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < L; i++) begin
          if (ready_vec[i] && !found) begin
            sel_vec[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Encode the one-hot selection and present that entry with sources marked ready.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < L; i++) begin
      if (sel_vec[i]) sel_idx = sel_idx | IDX_W'(i);
    end
    out_op          = ent_q[sel_idx];
    out_op.ra_ready = 1'b1;
    out_op.rt_ready = 1'b1;
  end

  // Incoming op with same-cycle broadcast bypass applied to its ready bits.
  always_comb begin
    disp_op = in_op;
    if (wb_hit(in_op.ra_addr, wb_valid, wb_addr)) disp_op.ra_ready = 1'b1;
    if (wb_hit(in_op.rt_addr, wb_valid, wb_addr)) disp_op.rt_ready = 1'b1;
  end

  // Entry next state: wakeup, issue retire, dispatch write; flush overrides all.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    for (int unsigned i = 0; i < L; i++) begin
      if (wb_hit(ent_q[i].ra_addr, wb_valid, wb_addr)) ent_d[i].ra_ready = 1'b1;
      if (wb_hit(ent_q[i].rt_addr, wb_valid, wb_addr)) ent_d[i].rt_ready = 1'b1;
    end
    if (issue_fire) valid_d = valid_d & ~sel_vec;
    if (disp_fire) begin
      ent_d[free_idx]   = disp_op;
      valid_d[free_idx] = 1'b1;
    end
    if (flush) valid_d = '0;
  end

  // Occupancy count tracks dispatch and issue; flush empties the queue.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({disp_fire, issue_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule
